// File: rtl/p2b_pkg.sv
// Shared constants, FSM states and lane/gear byte placement for the pixel-to-byte packer.
package p2b_pkg;

    localparam logic [5:0] DT_RAW10   = 6'h2B;
    localparam logic [5:0] DT_RGB888  = 6'h24;
    localparam int         FIFO_DEPTH = 16;
    localparam int         MAX_PUSH   = 5;   // RAW10 group: four MSB bytes plus one LSB byte
    localparam int         MAX_POP    = 8;   // widest word: 4 lanes x gear 16

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    // Bit offset of byte k inside a lane word of n_bytes bytes at the given gear.
    // Gear 8 puts one byte per lane at the bottom of each 16-bit lane slot; gear 16
    // fills the low byte of every lane first, then the high bytes.
    function automatic int byte_pos(input int k, input int n_bytes, input int gear);
        int lanes;
        int pos;
        lanes = n_bytes / 2;
        if (gear == 8)
            pos = 16 * k;
        else if (k < lanes)
            pos = 16 * k;
        else
            pos = 16 * (k - lanes) + 8;
        return pos;
    endfunction

endpackage

// File: rtl/p2b_byte_fifo.sv
// 16x8 byte FIFO: up to 5 bytes written and up to 8 bytes read per clock.
// The oldest RD_BYTES entries are always visible on rd_data for the output stage.
module p2b_byte_fifo
    import p2b_pkg::*;
#(
    parameter int RD_BYTES = 8
) (
    input  logic                             byte_clk,
    input  logic                             rst,
    input  logic [2:0]                       push_cnt,
    input  logic [MAX_PUSH-1:0][7:0]         push_data,
    input  logic [3:0]                       pop_cnt,
    output logic [RD_BYTES-1:0][7:0]         rd_data,
    output logic [4:0]                       count
);

    logic [7:0] mem [FIFO_DEPTH];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;

    // Pointers and occupancy; 4-bit pointers wrap naturally around the 16 entries.
    always_ff @(posedge byte_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + 4'(push_cnt);
            rd_ptr <= rd_ptr + pop_cnt;
            count  <= count + 5'(push_cnt) - 5'(pop_cnt);
        end
    end

    // Storage writes; contents need no reset because count gates every read.
    always_ff @(posedge byte_clk) begin
        for (int i = 0; i < MAX_PUSH; i++)
            if (3'(i) < push_cnt)
                mem[wr_ptr + 4'(i)] <= push_data[i];
    end

    // Peek window: byte k is the k-th oldest entry.
    always_comb begin
        for (int k = 0; k < RD_BYTES; k++)
            rd_data[k] = mem[rd_ptr + 4'(k)];
    end

endmodule

// File: rtl/pixel2byte_packer.sv
// Packs RAW10 / RGB888 pixels into bytes, buffers them and emits CSI-2 lane words
// (1/2/4 lanes, gear 8/16), padding and tagging the last word of each line.
module pixel2byte_packer
    import p2b_pkg::*;
#(
    parameter int          NUM_TX_LANE = 4,
    parameter int          TX_GEAR     = 8,
    parameter logic [5:0]  DATA_TYPE   = 6'h2B
) (
    input  logic          byte_clk,
    input  logic          rst,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [23:0]   pix_data,
    input  logic          pix_last,
    output logic          byte_en,
    output logic [63:0]   byte_dout,
    output logic          byte_last
);

    localparam int         N_BYTES    = NUM_TX_LANE * TX_GEAR / 8;
    localparam bit         IS_RAW     = (DATA_TYPE == DT_RAW10);
    localparam int         PUSH_BYTES = IS_RAW ? 5 : 3;
    localparam logic [4:0] READY_MAX  = 5'(FIFO_DEPTH - PUSH_BYTES);

    state_t                       state_q, state_d;
    logic [4:0]                   fifo_cnt;
    logic [4:0]                   cnt_next;
    logic [N_BYTES-1:0][7:0]      rd_data;
    logic [MAX_PUSH-1:0][7:0]     push_data;
    logic [2:0]                   push_cnt;
    logic [3:0]                   pop_cnt;
    logic                         pop_last;
    logic [1:0]                   grp_idx;
    logic [2:0][9:0]              stage;
    logic [3:0][9:0]              grp;
    logic                         ready_q;
    logic                         np_ok_q;
    logic                         accept;
    logic                         acc_last;
    logic [63:0]                  word;

    // RAW10 accepts that only stage a pixel never touch the FIFO, so they bypass
    // the space check; everything else waits on the registered space flag.
    assign pix_ready = ready_q | (IS_RAW && np_ok_q && grp_idx != 2'd3 && !pix_last);
    assign accept    = pix_valid & pix_ready;
    assign acc_last  = accept & pix_last;
    assign cnt_next  = fifo_cnt + 5'(push_cnt) - 5'(pop_cnt);

    // Byte packing for the accepted pixel; a short RAW10 group is zero-filled.
    always_comb begin
        push_cnt  = '0;
        push_data = '0;
        grp       = '0;
        if (IS_RAW) begin
            for (int i = 0; i < 3; i++)
                if (2'(i) < grp_idx)
                    grp[i] = stage[i];
            grp[grp_idx] = pix_data[9:0];
            for (int i = 0; i < 4; i++)
                push_data[i] = grp[i][9:2];
            push_data[4] = {grp[3][1:0], grp[2][1:0], grp[1][1:0], grp[0][1:0]};
            if (accept && (grp_idx == 2'd3 || pix_last))
                push_cnt = 3'd5;
        end else begin
            push_data[0] = pix_data[7:0];
            push_data[1] = pix_data[15:8];
            push_data[2] = pix_data[23:16];
            if (accept)
                push_cnt = 3'd3;
        end
    end

    // RAW10 staging of pixels 0..2; the group restarts after a push or line end.
    always_ff @(posedge byte_clk or posedge rst) begin
        if (rst) begin
            grp_idx <= '0;
            stage   <= '0;
        end else if (IS_RAW && accept) begin
            if (grp_idx == 2'd3 || pix_last) begin
                grp_idx <= '0;
            end else begin
                for (int i = 0; i < 3; i++)
                    if (grp_idx == 2'(i))
                        stage[i] <= pix_data[9:0];
                grp_idx <= grp_idx + 2'd1;
            end
        end
    end

    p2b_byte_fifo #(
        .RD_BYTES (N_BYTES)
    ) u_fifo (
        .byte_clk  (byte_clk),
        .rst       (rst),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .rd_data   (rd_data),
        .count     (fifo_cnt)
    );

    // Output FSM: word pops while streaming, drain plus zero-padded tail on flush.
    always_comb begin
        state_d  = state_q;
        pop_cnt  = '0;
        pop_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (push_cnt != 3'd0)
                    state_d = acc_last ? FLUSH : STREAM;
            end
            STREAM: begin
                if (fifo_cnt >= 5'(N_BYTES))
                    pop_cnt = 4'(N_BYTES);
                if (acc_last)
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (fifo_cnt >= 5'(N_BYTES)) begin
                    pop_cnt = 4'(N_BYTES);
                    if (fifo_cnt == 5'(N_BYTES)) begin
                        pop_last = 1'b1;
                        state_d  = IDLE;
                    end
                end else if (fifo_cnt != 5'd0) begin
                    pop_cnt  = 4'(fifo_cnt);
                    pop_last = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge byte_clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Ready flags from post-pop occupancy; held low for the whole flush.
    always_ff @(posedge byte_clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            np_ok_q <= 1'b0;
        end else begin
            ready_q <= (cnt_next <= READY_MAX) && (state_d != FLUSH);
            np_ok_q <= (state_d != FLUSH);
        end
    end

    // Lane word assembly; bytes beyond the pop count stay zero as padding.
    always_comb begin
        word = '0;
        for (int k = 0; k < N_BYTES; k++)
            if (4'(k) < pop_cnt)
                word[byte_pos(k, N_BYTES, TX_GEAR) +: 8] = rd_data[k];
    end

    // Output register, one clock behind the FIFO pop.
    always_ff @(posedge byte_clk or posedge rst) begin
        if (rst) begin
            byte_en   <= 1'b0;
            byte_dout <= '0;
            byte_last <= 1'b0;
        end else begin
            byte_en   <= (pop_cnt != 4'd0);
            byte_dout <= word;
            byte_last <= pop_last;
        end
    end

endmodule
